// File: rtl/dims_rtz_sequencer.sv
// dims_rtz_sequencer: clocked four-phase return-to-zero controller for a
// combinational DIMS dual-rail datapath. Operands arrive single-rail over
// valid/ready, are driven as dual-rail codewords followed by all-zero spacers,
// and the synchronised completion of the result rails is returned single-rail.
// Optional feature: define DIMS_LATENCY_CNT_EN to add the 16-bit lat_cyc
// output (cycles spent in DATA for the last captured result).
module dims_rtz_sequencer #(
  parameter int IN_W     = 8,
  parameter int OUT_W    = 9,
  parameter int INIT_CYC = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic [IN_W-1:0]  dr_f,
  output logic [IN_W-1:0]  dr_t,
  output logic             PI,
  input  logic [OUT_W-1:0] res_f,
  input  logic [OUT_W-1:0] res_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             err_timeout,
  output logic             err_illegal,
`ifdef DIMS_LATENCY_CNT_EN
  output logic [15:0]      lat_cyc,
`endif
  input  logic             clr_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_SPW  = 3'd1,
    S_IDLE = 3'd2,
    S_DATA = 3'd3,
    S_SPC  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // Rail-code classification of a whole dual-rail word.
  function automatic logic word_spacer(input logic [OUT_W-1:0] f, input logic [OUT_W-1:0] t);
    return ~|(f | t);
  endfunction

  function automatic logic word_complete(input logic [OUT_W-1:0] f, input logic [OUT_W-1:0] t);
    return &(f ^ t);
  endfunction

  function automatic logic word_illegal(input logic [OUT_W-1:0] f, input logic [OUT_W-1:0] t);
    return |(f & t);
  endfunction

  logic [OUT_W-1:0] res_f_m, res_t_m, res_f_s, res_t_s;
  state_t           state, state_nx;
  logic [IW-1:0]    init_cnt, init_cnt_nx;
  logic [1:0]       stab_cnt, stab_cnt_nx;
  logic [TW-1:0]    tmr, tmr_nx;
  logic             hs_done, hs_done_nx;
  logic             capture, set_timeout, set_illegal, clear_err;
  logic             spacer, complete, illegal, cond_now, stable, handshake, tmr_hit;
  logic             pi_nx, in_ready_nx, out_valid_nx, err_timeout_nx, err_illegal_nx;
  logic [IN_W-1:0]  dr_t_nx, dr_f_nx;
  logic [OUT_W-1:0] out_data_nx;

  assign spacer    = word_spacer(res_f_s, res_t_s);
  assign complete  = word_complete(res_f_s, res_t_s);
  assign illegal   = word_illegal(res_f_s, res_t_s);
  // DATA waits for a full codeword, every other waiting state for a spacer.
  assign cond_now  = (state == S_DATA) ? complete : spacer;
  // Condition already held for two full cycles and still holds now.
  assign stable    = cond_now && (stab_cnt == 2'd2);
  assign handshake = out_valid && out_ready;
  assign tmr_hit   = (tmr == TW'(TIMEOUT - 1));

  // Two-flop synchroniser for the asynchronous datapath result rails.
  always_ff @(posedge CK) begin
    if (RST) begin
      res_f_m <= {OUT_W{1'b0}};
      res_t_m <= {OUT_W{1'b0}};
      res_f_s <= {OUT_W{1'b0}};
      res_t_s <= {OUT_W{1'b0}};
    end else begin
      res_f_m <= res_f;
      res_t_m <= res_t;
      res_f_s <= res_f_m;
      res_t_s <= res_t_m;
    end
  end

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    stab_cnt_nx = stab_cnt;
    tmr_nx      = tmr;
    hs_done_nx  = hs_done;
    capture     = 1'b0;
    set_timeout = 1'b0;
    set_illegal = 1'b0;
    clear_err   = 1'b0;

    case (state)
      S_INIT: begin
        if (init_cnt == IW'(INIT_CYC - 1)) begin
          state_nx = S_SPW;
        end else begin
          init_cnt_nx = init_cnt + IW'(1);
        end
      end
      S_SPW: begin
        if (illegal) begin
          state_nx    = S_ERR;
          set_illegal = 1'b1;
        end else if (stable) begin
          state_nx = S_IDLE;
        end else if (tmr_hit) begin
          state_nx    = S_ERR;
          set_timeout = 1'b1;
        end else begin
          state_nx = state;
        end
      end
      S_IDLE: begin
        if (illegal) begin
          state_nx    = S_ERR;
          set_illegal = 1'b1;
        end else if (in_valid && in_ready) begin
          state_nx = S_DATA;
        end else begin
          state_nx = state;
        end
      end
      S_DATA: begin
        // Illegal code wins over a completion seen in the same cycle.
        if (illegal) begin
          state_nx    = S_ERR;
          set_illegal = 1'b1;
        end else if (stable) begin
          state_nx = S_SPC;
          capture  = 1'b1;
        end else if (tmr_hit) begin
          state_nx    = S_ERR;
          set_timeout = 1'b1;
        end else begin
          state_nx = state;
        end
      end
      S_SPC: begin
        // A stalled consumer never times out while the spacer is holding.
        if (illegal) begin
          state_nx    = S_ERR;
          set_illegal = 1'b1;
        end else if (stable && (hs_done || handshake)) begin
          state_nx = S_IDLE;
        end else if (tmr_hit && !spacer) begin
          state_nx    = S_ERR;
          set_timeout = 1'b1;
        end else begin
          state_nx = state;
        end
      end
      S_ERR: begin
        if (clr_err) begin
          state_nx  = S_INIT;
          clear_err = 1'b1;
        end else begin
          state_nx = state;
        end
      end
      default: begin
        state_nx = S_INIT;
      end
    endcase

    // Counters restart on every state change.
    if (state_nx != state) begin
      init_cnt_nx = {IW{1'b0}};
      stab_cnt_nx = 2'd0;
      tmr_nx      = {TW{1'b0}};
    end else begin
      if (cond_now) begin
        stab_cnt_nx = (stab_cnt == 2'd2) ? 2'd2 : stab_cnt + 2'd1;
      end else begin
        stab_cnt_nx = 2'd0;
      end
      if ((state == S_SPC) && spacer) begin
        tmr_nx = {TW{1'b0}};
      end else if ((state == S_SPW) || (state == S_DATA) || (state == S_SPC)) begin
        tmr_nx = tmr + TW'(1);
      end else begin
        tmr_nx = {TW{1'b0}};
      end
    end

    if (state_nx != S_SPC) begin
      hs_done_nx = 1'b0;
    end else if (handshake) begin
      hs_done_nx = 1'b1;
    end else begin
      hs_done_nx = hs_done;
    end

    pi_nx       = (state_nx == S_INIT) || (state_nx == S_ERR);
    in_ready_nx = (state_nx == S_IDLE);

    if (state_nx == S_DATA) begin
      if (state == S_IDLE) begin
        dr_t_nx = in_data;
        dr_f_nx = ~in_data;
      end else begin
        dr_t_nx = dr_t;
        dr_f_nx = dr_f;
      end
    end else begin
      dr_t_nx = {IN_W{1'b0}};
      dr_f_nx = {IN_W{1'b0}};
    end

    if ((state_nx == S_INIT) || (state_nx == S_ERR)) begin
      out_valid_nx = 1'b0;
    end else if (capture) begin
      out_valid_nx = 1'b1;
    end else if (handshake) begin
      out_valid_nx = 1'b0;
    end else begin
      out_valid_nx = out_valid;
    end

    out_data_nx = capture ? res_t_s : out_data;

    if (clear_err) begin
      err_timeout_nx = 1'b0;
      err_illegal_nx = 1'b0;
    end else begin
      err_timeout_nx = err_timeout | set_timeout;
      err_illegal_nx = err_illegal | set_illegal;
    end
  end

  // State, counters and registered outputs; RST restarts from INIT at any time.
  always_ff @(posedge CK) begin
    if (RST) begin
      state       <= S_INIT;
      init_cnt    <= {IW{1'b0}};
      stab_cnt    <= 2'd0;
      tmr         <= {TW{1'b0}};
      hs_done     <= 1'b0;
      PI          <= 1'b1;
      in_ready    <= 1'b0;
      dr_t        <= {IN_W{1'b0}};
      dr_f        <= {IN_W{1'b0}};
      out_valid   <= 1'b0;
      out_data    <= {OUT_W{1'b0}};
      err_timeout <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_nx;
      init_cnt    <= init_cnt_nx;
      stab_cnt    <= stab_cnt_nx;
      tmr         <= tmr_nx;
      hs_done     <= hs_done_nx;
      PI          <= pi_nx;
      in_ready    <= in_ready_nx;
      dr_t        <= dr_t_nx;
      dr_f        <= dr_f_nx;
      out_valid   <= out_valid_nx;
      out_data    <= out_data_nx;
      err_timeout <= err_timeout_nx;
      err_illegal <= err_illegal_nx;
    end
  end

`ifdef DIMS_LATENCY_CNT_EN
  logic [15:0] lat_cnt;

  // Count cycles spent in DATA and publish the count when the result is captured.
  always_ff @(posedge CK) begin
    if (RST) begin
      lat_cnt <= 16'd0;
      lat_cyc <= 16'd0;
    end else begin
      if ((state_nx == S_DATA) && (state != S_DATA)) begin
        lat_cnt <= 16'd1;
      end else if ((state == S_DATA) && (lat_cnt != 16'hFFFF)) begin
        lat_cnt <= lat_cnt + 16'd1;
      end else begin
        lat_cnt <= lat_cnt;
      end
      if (capture) begin
        lat_cyc <= lat_cnt;
      end else begin
        lat_cyc <= lat_cyc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dims_rtz_sequencer.sv
// Bench for dims_rtz_sequencer: a behavioural model of the controller, a
// delayed-echo datapath model, per-cycle output comparison plus directed
// literal checks of reset length, latency, backpressure, timeout and illegal.
module tb_dims_rtz_sequencer;
  localparam int IN_W = 8, OUT_W = 9, INIT_CYC = 4, TIMEOUT = 255;

  logic             CK = 1'b0;
  logic             RST = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic [IN_W-1:0]  dr_f, dr_t;
  logic             PI;
  logic [OUT_W-1:0] res_f = '0;
  logic [OUT_W-1:0] res_t = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic             err_timeout, err_illegal;
  logic             clr_err = 1'b0;
`ifdef DIMS_LATENCY_CNT_EN
  logic [15:0]      lat_cyc;
`endif

  always #5 CK = ~CK;

  dims_rtz_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .INIT_CYC(INIT_CYC), .TIMEOUT(TIMEOUT)) dut (
    .CK(CK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dr_f(dr_f), .dr_t(dr_t), .PI(PI), .res_f(res_f), .res_t(res_t),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_timeout(err_timeout), .err_illegal(err_illegal),
`ifdef DIMS_LATENCY_CNT_EN
    .lat_cyc(lat_cyc),
`endif
    .clr_err(clr_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- datapath model: echoes the rails after dly cycles ----------------
  // mode 0: echo (bit 8 false rail high whenever a codeword is present)
  // mode 1: never completes (result stays spacer)
  // mode 2: echo with bit 3 driven illegal (both rails high) during a codeword
  int dly = 0;
  int dp_mode = 0;
  logic [2*IN_W-1:0] hist [16] = '{default: '0};

  always @(posedge CK) begin
    logic [IN_W-1:0] vt, vf;
    logic [OUT_W-1:0] nt, nf;
    #1;
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {dr_t, dr_f};
    vt = hist[dly][2*IN_W-1:IN_W];
    vf = hist[dly][IN_W-1:0];
    nt = {1'b0, vt};
    nf = {|(vt | vf), vf};
    if (dp_mode == 1) begin
      nt = '0;
      nf = '0;
    end else if (dp_mode == 2 && (|(vt | vf))) begin
      nt[3] = 1'b1;
      nf[3] = 1'b1;
    end
    res_t = nt;
    res_f = nf;
  end

  // ---------------- behavioural reference model ----------------
  typedef enum {P_INIT, P_SPW, P_IDLE, P_DATA, P_SPC, P_ERR} phase_e;
  phase_e ph = P_INIT;
  int age = 0, run = 0, dirty = 0;
  bit taken = 0, live = 0;
  logic [OUT_W-1:0] s1f = '0, s1t = '0, s2f = '0, s2t = '0;
  logic e_pi = 1, e_ir = 0, e_ov = 0, e_to = 0, e_il = 0;
  logic [IN_W-1:0] e_dt = '0, e_df = '0;
  logic [OUT_W-1:0] e_od = '0;

  always @(posedge CK) begin
    logic [OUT_W-1:0] sf, st;
    phase_e nph;
    bit sp, cp, il, cond, settled, hs, cap;
    // the synchronised word the controller decided on during the ending cycle
    sf = s2f; st = s2t;
    s2f = s1f; s2t = s1t;
    s1f = res_f; s1t = res_t;
    if (RST) begin
      live = 1; ph = P_INIT; age = 0; run = 0; dirty = 0; taken = 0;
      s1f = '0; s1t = '0; s2f = '0; s2t = '0;
      e_pi = 1; e_ir = 0; e_ov = 0; e_to = 0; e_il = 0;
      e_dt = '0; e_df = '0; e_od = '0;
    end else if (live) begin
      sp = ((sf | st) == '0);
      cp = ((sf ^ st) == '1);
      il = ((sf & st) != '0);
      cond = (ph == P_DATA) ? cp : sp;
      settled = cond && (run >= 2);
      hs = e_ov && out_ready;
      nph = ph;
      cap = 0;
      if (ph != P_INIT && ph != P_ERR && il) begin
        nph = P_ERR;
        e_il = 1;
      end else begin
        case (ph)
          P_INIT: if (age == INIT_CYC - 1) nph = P_SPW;
          P_SPW:  if (settled) nph = P_IDLE;
                  else if (age == TIMEOUT - 1) begin nph = P_ERR; e_to = 1; end
          P_IDLE: if (in_valid) nph = P_DATA;
          P_DATA: if (settled) begin nph = P_SPC; cap = 1; end
                  else if (age == TIMEOUT - 1) begin nph = P_ERR; e_to = 1; end
          P_SPC:  if (settled && (taken || hs)) nph = P_IDLE;
                  else if (!sp && dirty == TIMEOUT - 1) begin nph = P_ERR; e_to = 1; end
          P_ERR:  if (clr_err) begin nph = P_INIT; e_to = 0; e_il = 0; end
          default: nph = P_INIT;
        endcase
      end
      if (cap) e_od = st;
      if (nph == P_INIT || nph == P_ERR) e_ov = 0;
      else if (cap) e_ov = 1;
      else if (hs) e_ov = 0;
      taken = (nph == P_SPC) && (taken || hs);
      if (nph == P_DATA && ph == P_IDLE) begin
        e_dt = in_data;
        e_df = ~in_data;
      end else if (nph != P_DATA) begin
        e_dt = '0;
        e_df = '0;
      end
      if (nph != ph) begin
        age = 0; run = 0; dirty = 0;
      end else begin
        age++;
        run = cond ? run + 1 : 0;
        dirty = sp ? 0 : dirty + 1;
      end
      ph = nph;
      e_pi = (ph == P_INIT) || (ph == P_ERR);
      e_ir = (ph == P_IDLE);
    end
  end

  // compare every registered output against the model, away from the active edge
  always @(negedge CK) begin
    if (live) begin
      check("PI", {31'b0, PI}, {31'b0, e_pi});
      check("in_ready", {31'b0, in_ready}, {31'b0, e_ir});
      check("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
      check("err_timeout", {31'b0, err_timeout}, {31'b0, e_to});
      check("err_illegal", {31'b0, err_illegal}, {31'b0, e_il});
      check("dr_t", {24'b0, dr_t}, {24'b0, e_dt});
      check("dr_f", {24'b0, dr_f}, {24'b0, e_df});
      check("out_data", {23'b0, out_data}, {23'b0, e_od});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CK);
    #2;
  endtask

  function automatic logic probe(input int which);
    case (which)
      0: return PI;
      1: return in_ready;
      2: return out_valid;
      3: return err_timeout;
      4: return err_illegal;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input string name, input int which, input logic level,
                            input int budget, output int n);
    n = 0;
    while (probe(which) !== level && n < budget) begin
      tick();
      n++;
    end
    if (probe(which) !== level) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: level %0b not seen within %0d cycles", name, level, budget);
    end
  endtask

  task automatic send(input logic [IN_W-1:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    // reset: RST high for two cycles
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    check("rst_pi", {31'b0, PI}, 32'd1);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    wait_until("init_len", 0, 1'b0, 20, n);
    check("init_len", n, 32'd4);
    wait_until("spacer_wait_len", 1, 1'b1, 20, n);
    check("spacer_wait_len", n, 32'd3);

    // operand 0x5A, datapath echoes after 3 cycles
    dly = 3;
    out_ready = 1'b1;
    send(8'h5A);
    check("drive_t", {24'b0, dr_t}, 32'h5A);
    check("drive_f", {24'b0, dr_f}, 32'hA5);
    wait_until("lat_5A", 2, 1'b1, 30, n);
    check("lat_5A", n, 32'd8);
    check("result_5A", {23'b0, out_data}, 32'h05A);
    check("rails_rtz", {24'b0, dr_t | dr_f}, 32'd0);
    wait_until("back_idle", 1, 1'b1, 40, n);

    // backpressure: consumer stalls 20 cycles
    dly = 0;
    out_ready = 1'b0;
    send(8'h5A);
    wait_until("bp_valid", 2, 1'b1, 30, n);
    check("lat_min", n, 32'd5);
    repeat (20) tick();
    check("bp_hold_data", {23'b0, out_data}, 32'h05A);
    check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    check("bp_release_valid", {31'b0, out_valid}, 32'd0);

    // timeout: datapath never completes
    dp_mode = 1;
    send(8'h33);
    wait_until("timeout_len", 3, 1'b1, 300, n);
    check("timeout_len", n, 32'd255);
    check("timeout_pi", {31'b0, PI}, 32'd1);
    dp_mode = 0;
    repeat (3) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_timeout", {31'b0, err_timeout}, 32'd0);
    wait_until("clr_recover", 1, 1'b1, 30, n);
    check("clr_recover", n, 32'd7);

    // illegal code on bit 3 during DATA
    dp_mode = 2;
    dly = 1;
    send(8'hC3);
    wait_until("illegal_lat", 4, 1'b1, 30, n);
    check("illegal_lat", n, 32'd4);
    check("illegal_no_valid", {31'b0, out_valid}, 32'd0);
    check("illegal_pi", {31'b0, PI}, 32'd1);
    dp_mode = 0;
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    wait_until("illegal_recover", 1, 1'b1, 40, n);

    // RST in the middle of DATA
    dly = 6;
    send(8'h81);
    tick();
    RST = 1'b1;
    tick();
    check("rst_mid_rails", {24'b0, dr_t | dr_f}, 32'd0);
    check("rst_mid_pi", {31'b0, PI}, 32'd1);
    check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    RST = 1'b0;
    wait_until("rst_mid_recover", 1, 1'b1, 60, n);

    // randomized traffic, model checks every cycle
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) dly = $urandom_range(0, 5);
      dp_mode = ((i % 300) >= 285) ? 2 : 0;
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_err = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_valid = 1'b0;
    clr_err = 1'b0;
    dp_mode = 0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
